// File: rtl/uart_key_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_key_checker                                           |
// | Description : Collects an 8-byte key from the UART rx byte stream,       |
// |               compares it with a constant key and answers each attempt   |
// |               with one verdict byte. Optional lockout after a wrong key  |
// |               is built when UART_KEY_LOCKOUT_EN is defined.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_key_checker #(
    parameter logic [63:0] KEY            = 64'h1DA6_4D9B_5D1F_6822,
    parameter logic [7:0]  RESP_OK        = 8'h2B,
    parameter logic [7:0]  RESP_BAD       = 8'h2D,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          LOCKOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       unlocked,
    output logic       busy
);

    localparam int c_TIMER_MAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int c_TIMER_W   = $clog2(c_TIMER_MAX);

    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE    = c_TIMER_W'(1);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
`ifdef UART_KEY_LOCKOUT_EN
    localparam logic [c_TIMER_W-1:0] c_LOCKOUT_LAST = c_TIMER_W'(LOCKOUT_CYCLES - 1);
`endif

    localparam logic [1:0] c_ST_COLLECT = 2'd0;
    localparam logic [1:0] c_ST_RESPOND = 2'd1;
`ifdef UART_KEY_LOCKOUT_EN
    localparam logic [1:0] c_ST_LOCKOUT = 2'd2;
`endif

    logic [1:0]           r_state;
    logic [2:0]           r_idx;
    logic                 r_mismatch;
    logic [c_TIMER_W-1:0] r_timer;
    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;
    logic                 r_unlocked;
    logic                 r_busy;

    logic [7:0]           w_key_byte;
    logic                 w_mismatch_next;

    assign w_key_byte      = KEY[{r_idx, 3'b000} +: 8];
    assign w_mismatch_next = r_mismatch | (rx_data != w_key_byte);

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign unlocked = r_unlocked;
    assign busy     = r_busy;

    // r_mismatch is kept through RESPOND so it still carries the verdict at the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_COLLECT;
            r_idx      <= 3'd0;
            r_mismatch <= 1'b0;
            r_timer    <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_unlocked <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_COLLECT: begin
                    if (rx_valid) begin
                        r_mismatch <= w_mismatch_next;
                        r_timer    <= '0;
                        if (r_idx == 3'd7) begin
                            r_state    <= c_ST_RESPOND;
                            r_busy     <= 1'b1;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= w_mismatch_next ? RESP_BAD : RESP_OK;
                            if (!w_mismatch_next) begin
                                r_unlocked <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else if (r_idx != 3'd0) begin
                        // A byte arriving on the timeout edge takes the branch above instead.
                        if (r_timer == c_TIMEOUT_LAST) begin
                            r_idx      <= 3'd0;
                            r_mismatch <= 1'b0;
                            r_timer    <= '0;
                        end else begin
                            r_timer <= r_timer + c_TIMER_ONE;
                        end
                    end
                end

                c_ST_RESPOND: begin
                    if (r_tx_valid && tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_idx      <= 3'd0;
                        r_mismatch <= 1'b0;
`ifdef UART_KEY_LOCKOUT_EN
                        if (r_mismatch) begin
                            r_state <= c_ST_LOCKOUT;
                        end else begin
                            r_state <= c_ST_COLLECT;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= c_ST_COLLECT;
                        r_busy  <= 1'b0;
`endif
                    end
                end

`ifdef UART_KEY_LOCKOUT_EN
                c_ST_LOCKOUT: begin
                    if (r_timer == c_LOCKOUT_LAST) begin
                        r_timer <= '0;
                        r_state <= c_ST_COLLECT;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + c_TIMER_ONE;
                    end
                end
`endif

                default: begin
                    r_state    <= c_ST_COLLECT;
                    r_idx      <= 3'd0;
                    r_mismatch <= 1'b0;
                    r_timer    <= '0;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_key_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_key_checker                                        |
// | Description : Self-checking bench for uart_key_checker with a gap-based  |
// |               attempt model, directed scenarios and random attempts.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_key_checker;

    localparam logic [63:0] c_KEY          = 64'h1DA6_4D9B_5D1F_6822;
    localparam logic [7:0]  c_RESP_OK      = 8'h2B;
    localparam logic [7:0]  c_RESP_BAD     = 8'h2D;
    localparam int          c_TIMEOUT      = 256;
    localparam int          c_LOCKOUT      = 4096;
`ifdef UART_KEY_LOCKOUT_EN
    localparam bit          c_LOCK         = 1'b1;
`else
    localparam bit          c_LOCK         = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       unlocked;
    logic       busy;

    int total = 0;
    int bad   = 0;
    bit rand_ready = 1'b0;

    uart_key_checker dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .unlocked (unlocked),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an attempt is the list of bytes accepted so far; a gap longer
    // than the timeout between accepted bytes discards it.
    logic [7:0]  m_q[$];
    logic [63:0] m_word;
    int          m_e    = 0;
    int          m_last = 0;
    bit          m_pend = 1'b0;
    logic [7:0]  m_txd  = 8'h00;
    bit          m_unl  = 1'b0;
    int          m_lock = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_e = 0; m_last = 0; m_pend = 1'b0; m_unl = 1'b0; m_lock = 0;
        end else begin
            m_e++;
            if (m_pend) begin
                if (tx_ready) begin
                    m_pend = 1'b0;
                    if (c_LOCK && m_txd == c_RESP_BAD) m_lock = c_LOCKOUT;
                end
            end else if (m_lock > 0) begin
                m_lock--;
            end else if (rx_valid) begin
                m_q.push_back(rx_data);
                m_last = m_e;
                if (m_q.size() == 8) begin
                    m_word = {m_q[7], m_q[6], m_q[5], m_q[4], m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_pend = 1'b1;
                    m_txd  = (m_word == c_KEY) ? c_RESP_OK : c_RESP_BAD;
                    if (m_word == c_KEY) m_unl = 1'b1;
                    m_q.delete();
                end
            end else if (m_q.size() > 0 && (m_e - m_last) == c_TIMEOUT) begin
                m_q.delete();
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            check("tx_valid", tx_valid, m_pend);
            check("busy", busy, (m_pend || m_lock > 0));
            check("unlocked", unlocked, m_unl);
            if (m_pend) check("tx_data", tx_data, m_txd);
        end
    end

    int hs_ok  = 0;
    int hs_bad = 0;
    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (tx_data == c_RESP_OK) hs_ok++;
            else hs_bad++;
        end
    end

    task automatic drive_cycle(input bit v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00);
    endtask

    task automatic send_bytes(input logic [63:0] k, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            drive_cycle(1'b1, k[8*i +: 8]);
            if (i != last) idle(gap - 1);
        end
        drive_cycle(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_unlocked", unlocked, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_hs(input string tag, input int ok0, input int bad0, input int dok, input int dbad);
        check({tag, "_ok_count"}, hs_ok - ok0, dok);
        check({tag, "_bad_count"}, hs_bad - bad0, dbad);
    endtask

    initial begin
        logic [63:0] k;
        int ok0, bad0, p, gap, r;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("init_tx_valid", tx_valid, 1'b0);
        check("init_tx_data", tx_data, 8'h00);
        check("init_unlocked", unlocked, 1'b0);
        check("init_busy", busy, 1'b0);
        rst = 1'b0;

        // Correct key, bytes 20 clocks apart.
        ok0 = hs_ok; bad0 = hs_bad;
        send_bytes(c_KEY, 0, 7, 20);
        idle(5);
        expect_hs("s1", ok0, bad0, 1, 0);
        check("s1_unlocked", unlocked, 1'b1);
        check("s1_busy", busy, 1'b0);

        // Wrong first byte, then an immediate correct retry.
        do_reset();
        ok0 = hs_ok; bad0 = hs_bad;
        k = c_KEY; k[7:0] = 8'h23;
        send_bytes(k, 0, 7, 3);
        idle(3);
        expect_hs("s2_wrong", ok0, bad0, 0, 1);
        check("s2_unlocked", unlocked, 1'b0);
        send_bytes(c_KEY, 0, 7, 2);
        idle(5);
        expect_hs("s2_retry", ok0, bad0, c_LOCK ? 0 : 1, 1);

        // Partial key abandoned by timeout.
        do_reset();
        ok0 = hs_ok; bad0 = hs_bad;
        send_bytes(c_KEY, 0, 2, 4);
        idle(300);
        send_bytes(c_KEY, 0, 7, 4);
        idle(5);
        expect_hs("s3", ok0, bad0, 1, 0);

        // Verdict held with tx_ready low while junk arrives.
        ok0 = hs_ok; bad0 = hs_bad;
        tx_ready = 1'b0;
        send_bytes(c_KEY, 0, 7, 3);
        for (int i = 0; i < 50; i++) drive_cycle(i[0], 8'($urandom));
        check("s4_hold_valid", tx_valid, 1'b1);
        check("s4_hold_data", tx_data, c_RESP_OK);
        expect_hs("s4_hold", ok0, bad0, 0, 0);
        tx_ready = 1'b1;
        idle(3);
        send_bytes(c_KEY, 0, 7, 2);
        idle(3);
        expect_hs("s4", ok0, bad0, 2, 0);

        // Reset mid-key, then full key.
        do_reset();
        ok0 = hs_ok; bad0 = hs_bad;
        send_bytes(c_KEY, 0, 3, 2);
        do_reset();
        send_bytes(c_KEY, 0, 7, 2);
        idle(3);
        expect_hs("s5", ok0, bad0, 1, 0);

        // Byte on the exact timeout edge is kept.
        do_reset();
        ok0 = hs_ok; bad0 = hs_bad;
        send_bytes(c_KEY, 0, 2, 1);
        idle(c_TIMEOUT - 2);
        send_bytes(c_KEY, 3, 7, 1);
        idle(3);
        expect_hs("s6", ok0, bad0, 1, 0);

        // Reset while a verdict waits drops it.
        ok0 = hs_ok; bad0 = hs_bad;
        tx_ready = 1'b0;
        send_bytes(c_KEY, 0, 7, 1);
        do_reset();
        tx_ready = 1'b1;
        idle(3);
        expect_hs("s7", ok0, bad0, 0, 0);

        // Random attempts, gaps and tx_ready back-pressure.
        rand_ready = 1'b1;
        for (int a = 0; a < 12; a++) begin
            k = c_KEY;
            if ($urandom_range(0, 1) == 1) begin
                p = $urandom_range(0, 7);
                k[8*p +: 8] = k[8*p +: 8] ^ 8'($urandom_range(1, 255));
            end
            r = $urandom_range(0, 9);
            if (r < 7) gap = $urandom_range(1, 6);
            else if (r < 9) gap = $urandom_range(c_TIMEOUT - 6, c_TIMEOUT + 6);
            else gap = 1;
            send_bytes(k, 0, 7, gap);
            if ($urandom_range(0, 3) == 0) drive_cycle(1'b1, 8'($urandom));
            idle($urandom_range(0, 10));
        end
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        idle(c_LOCK ? c_LOCKOUT + 50 : 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
